// File: rtl/throttle_pkg.sv
// Shared types and limits for the accelerometer throttle filter.
// Holds the FSM state encoding and the sample/setting widths and range.
package throttle_pkg;

  typedef enum logic [1:0] {
    FILL,
    RUN,
    KILL
  } state_t;

  localparam int SAMPLE_W    = 12;
  localparam int SETTING_W   = 10;
  localparam int SETTING_MAX = 511;
  localparam int SETTING_MIN = -511;

endpackage

// File: rtl/moving_avg_buffer.sv
// Circular sample window with running sum over the last 2**pAvgLog2 samples.
// Ports: clk, rst_n, sample_in/sample_valid in; sum (signed), filled out.
module moving_avg_buffer
  import throttle_pkg::*;
#(
  parameter int pAvgLog2 = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [SAMPLE_W-1:0]          sample_in,
  input  logic                         sample_valid,
  output logic [SAMPLE_W+pAvgLog2-1:0] sum,
  output logic                         filled
);

  localparam int WIN   = 1 << pAvgLog2;
  localparam int CW    = pAvgLog2 + 1;
  localparam int SUM_W = SAMPLE_W + pAvgLog2;

  logic [SAMPLE_W-1:0] mem [WIN];
  logic [pAvgLog2-1:0] wp;
  logic [CW-1:0]       cnt;
  logic [SUM_W-1:0]    add_term;
  logic [SUM_W-1:0]    sub_term;

  assign filled   = (cnt == CW'(WIN));
  assign add_term = SUM_W'($signed(sample_in));
  // Slots are unwritten until the window fills; they count as zero.
  assign sub_term = filled ? SUM_W'($signed(mem[wp])) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
      wp  <= '0;
      cnt <= '0;
    end else if (sample_valid) begin
      sum <= sum + add_term - sub_term;
      wp  <= wp + 1'b1;
      if (!filled) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sample_valid) begin
      mem[wp] <= sample_in;
    end
  end

endmodule

// File: rtl/accel_throttle_filter.sv
// Averages, scales, deadbands, clamps and slew-limits accel samples into PWMsetting.
// Ports: CLOCK_50, RESET_N, sample_in/valid, enable in; PWMsetting, setting_valid, filled out.
module accel_throttle_filter
  import throttle_pkg::*;
#(
  parameter int pAvgLog2  = 3,
  parameter int pShift    = 2,
  parameter int pDeadband = 12,
  parameter int pSlewStep = 4,
  parameter int pTickDiv  = 50000
) (
  input  logic                 CLOCK_50,
  input  logic                 RESET_N,
  input  logic [SAMPLE_W-1:0]  sample_in,
  input  logic                 sample_valid,
  input  logic                 enable,
  output logic [SETTING_W-1:0] PWMsetting,
  output logic                 setting_valid,
  output logic                 filled
);

  localparam int SUM_W = SAMPLE_W + pAvgLog2;
  localparam int TW    = (pTickDiv > 1) ? $clog2(pTickDiv) : 1;
  localparam int DW    = SETTING_W + 1;

  localparam logic signed [SUM_W-1:0] DB   = SUM_W'(pDeadband);
  localparam logic signed [SUM_W-1:0] MAXV = SUM_W'(SETTING_MAX);
  localparam logic signed [SUM_W-1:0] MINV = SUM_W'(SETTING_MIN);
  localparam logic signed [DW-1:0]    STEP = DW'(pSlewStep);

  logic [SUM_W-1:0]        avg_sum;
  logic signed [SUM_W-1:0] avg;
  logic signed [SUM_W-1:0] scaled;
  logic                    in_band;
  logic [SETTING_W-1:0]    tgt_d;
  logic [SETTING_W-1:0]    tgt_q;
  logic signed [DW-1:0]    diff;
  logic [SETTING_W-1:0]    slew;
  logic [TW-1:0]           tcnt;
  logic                    tick;
  state_t                  state_q;
  state_t                  state_d;
  logic [SETTING_W-1:0]    pwm_d;
  logic                    sv_d;

  moving_avg_buffer #(
    .pAvgLog2(pAvgLog2)
  ) u_avg (
    .clk         (CLOCK_50),
    .rst_n       (RESET_N),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .sum         (avg_sum),
    .filled      (filled)
  );

  assign avg     = $signed(avg_sum) >>> pAvgLog2;
  assign scaled  = avg >>> pShift;
  assign in_band = (scaled < DB) && (scaled > -DB);

  // -512 is clamped to -511 so the PWM stage can negate safely.
  always_comb begin
    tgt_d = scaled[SETTING_W-1:0];
    if (in_band) begin
      tgt_d = '0;
    end else if (scaled > MAXV) begin
      tgt_d = MAXV[SETTING_W-1:0];
    end else if (scaled < MINV) begin
      tgt_d = MINV[SETTING_W-1:0];
    end
  end

  assign diff = {tgt_q[SETTING_W-1], tgt_q}
              - {PWMsetting[SETTING_W-1], PWMsetting};

  always_comb begin
    slew = tgt_q;
    unique case (1'b1)
      (diff > STEP):  slew = PWMsetting + STEP[SETTING_W-1:0];
      (diff < -STEP): slew = PWMsetting - STEP[SETTING_W-1:0];
      default:        slew = tgt_q;
    endcase
  end

  assign tick = (tcnt == TW'(pTickDiv - 1));

  // Enable low is checked before tick so a kill never emits a strobe.
  always_comb begin
    state_d = state_q;
    pwm_d   = PWMsetting;
    sv_d    = 1'b0;
    unique case (state_q)
      FILL: begin
        pwm_d = '0;
        if (filled) begin
          state_d = enable ? RUN : KILL;
        end
      end
      RUN: begin
        if (!enable) begin
          pwm_d   = '0;
          state_d = KILL;
        end else if (tick) begin
          pwm_d = slew;
          sv_d  = 1'b1;
        end
      end
      KILL: begin
        pwm_d = '0;
        if (enable) begin
          state_d = RUN;
        end
      end
      default: begin
        pwm_d   = '0;
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= FILL;
      PWMsetting    <= '0;
      setting_valid <= 1'b0;
      tgt_q         <= '0;
      tcnt          <= '0;
    end else begin
      state_q       <= state_d;
      PWMsetting    <= pwm_d;
      setting_valid <= sv_d;
      tgt_q         <= tgt_d;
      tcnt          <= tick ? '0 : tcnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_accel_throttle_filter.sv
// Randomized scoreboard bench for accel_throttle_filter with a window-based model.
// Model predicts outputs per cycle; a monitor pops expected settings on setting_valid.
module tb_accel_throttle_filter;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        sv    = 1'b0;
  logic        en    = 1'b0;
  logic [11:0] s_in  = '0;
  logic [9:0]  pwm;
  logic        set_v;
  logic        fil;

  int vectors     = 0;
  int miscompares = 0;
  int exp_q[$];

  int hist[$];
  int m_sum    = 0;
  int m_tgt    = 0;
  int m_pwm    = 0;
  int m_cnt    = 0;
  int m_n      = 0;
  int m_mode   = 0;
  bit m_filled = 1'b0;
  bit m_sv     = 1'b0;

  always #10 clk = ~clk;

  accel_throttle_filter #(
    .pTickDiv(10)
  ) dut (
    .CLOCK_50     (clk),
    .RESET_N      (rst_n),
    .sample_in    (s_in),
    .sample_valid (sv),
    .enable       (en),
    .PWMsetting   (pwm),
    .setting_valid(set_v),
    .filled       (fil)
  );

  function automatic int floor_div(int a, int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  function automatic int target_of(int s);
    int t;
    t = floor_div(floor_div(s, 8), 4);
    if (t < 12 && t > -12) t = 0;
    if (t > 511) t = 511;
    if (t < -511) t = -511;
    return t;
  endfunction

  task automatic check(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model, evaluated on each active edge from pre-edge values.
  initial begin
    int  o_tgt;
    bit  o_fil;
    bit  tk;
    int  d;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        hist.delete();
        exp_q.delete();
        m_sum = 0; m_tgt = 0; m_pwm = 0; m_cnt = 0;
        m_n = 0; m_mode = 0; m_filled = 0; m_sv = 0;
      end else begin
        o_tgt = m_tgt;
        o_fil = m_filled;
        tk    = (m_cnt == 9);
        m_sv  = 0;
        case (m_mode)
          0: begin
            m_pwm = 0;
            if (o_fil) m_mode = en ? 1 : 2;
          end
          1: begin
            if (!en) begin
              m_pwm  = 0;
              m_mode = 2;
            end else if (tk) begin
              d = o_tgt - m_pwm;
              if (d > 4) d = 4;
              if (d < -4) d = -4;
              m_pwm = m_pwm + d;
              m_sv  = 1;
              exp_q.push_back(m_pwm);
            end
          end
          default: begin
            m_pwm = 0;
            if (en) m_mode = 1;
          end
        endcase
        m_tgt = target_of(m_sum);
        if (sv) begin
          hist.push_back(int'($signed(s_in)));
          if (hist.size() > 8) void'(hist.pop_front());
          m_n++;
        end
        m_sum = 0;
        foreach (hist[i]) m_sum += hist[i];
        m_filled = (m_n >= 8);
        m_cnt = (m_cnt + 1) % 10;
      end
    end
  end

  // Monitor: per-cycle comparison plus scoreboard pop on setting_valid.
  initial begin
    forever begin
      @(negedge clk);
      check("pwm", int'($signed(pwm)), m_pwm);
      check("setting_valid", int'(set_v), int'(m_sv));
      check("filled", int'(fil), int'(m_filled));
      check("sum", int'($signed(dut.avg_sum)), m_sum);
      if (set_v) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL scoreboard: setting_valid with value %0d, none expected at %0t",
                   $signed(pwm), $time);
        end else begin
          check("scoreboard", int'($signed(pwm)), exp_q.pop_front());
        end
      end
    end
  end

  task automatic send(int v);
    @(negedge clk);
    s_in = 12'(v);
    sv   = 1'b1;
    @(negedge clk);
    sv   = 1'b0;
  endtask

  task automatic send8(int v);
    repeat (8) send(v);
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pwm(int v, int limit);
    bit ok;
    ok = 0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      if (int'($signed(pwm)) == v) ok = 1;
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL wait_pwm: got %0d required %0d within %0d cycles",
               $signed(pwm), v, limit);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    check("reset_pwm", int'(pwm), 0);
    check("reset_sv", int'(set_v), 0);
    check("reset_filled", int'(fil), 0);
    rst_n = 1'b1;
    en    = 1'b1;

    send8(800);
    idle(700);
    check("step_final", int'($signed(pwm)), 200);

    send8(40);
    idle(800);
    check("deadband", int'($signed(pwm)), 0);

    send8(-2048);
    idle(1500);
    check("clamp_bits", int'(pwm), 'h201);

    send8(480);
    wait_pwm(120, 2500);
    en = 1'b0;
    @(negedge clk);
    check("kill_pwm", int'($signed(pwm)), 0);
    check("kill_sv", int'(set_v), 0);
    idle(30);
    en = 1'b1;
    idle(400);
    check("rearm", int'($signed(pwm)), 120);

    send8(400);
    idle(200);
    check("rev_pos", int'($signed(pwm)), 100);
    send8(-400);
    idle(700);
    check("rev_neg", int'($signed(pwm)), -100);

    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      s_in = 12'($urandom);
      sv   = 1'b1;
    end
    @(negedge clk);
    sv = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      sv   = 1'($urandom_range(0, 1));
      s_in = 12'($urandom);
      if ($urandom_range(0, 99) == 0) en = ~en;
    end
    @(negedge clk);
    sv = 1'b0;
    en = 1'b1;

    send8(1600);
    idle(150);
    #3 rst_n = 1'b0;
    #1;
    check("async_pwm", int'(pwm), 0);
    check("async_filled", int'(fil), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (7) send(100);
    check("fill7", int'(fil), 0);
    send(100);
    check("fill8", int'(fil), 1);
    idle(60);
    check("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
